ram_port_arbiter: RTL and testbench

- Shares one memory-controller port (en/we/addr/din/dout) between two requesters (0 and 1).
- Round-robin arbitration, registered command issue, and a one-cycle read→write turnaround bubble.
- Tags each read with its requester ID through a delay line matching the memory read latency, so read data returns to the right requester.
- Sits between test/host agents and one port of the dual-port memory controller; one instance per memory port.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/rd_tag_pipe.sv | 33 +++
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package ram_arb_pkg;

   localparam int unsigned A_W_DEF = 8;
   localparam int unsigned D_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      TURN  = 2'd2
   } arb_state_e;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: carries {valid, requester id} alongside the memory read latency.
module rd_tag_pipe
   import ram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out,
   output logic    any_valid
);

   rd_tag_t stage [DEPTH];

   // Shift tags one stage per cycle; reset discards everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
   end

   // Tail tag and an any-read-outstanding flag.
   always_comb begin
      tag_out   = stage[DEPTH-1];
      any_valid = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) any_valid = any_valid | stage[i].valid;
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, with
// read->write turnaround bubble and id-tagged read return.
// Optional macro RAM_ARB_ECC_EN adds mem_error / rsp_error / err_cnt.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned A_W      = A_W_DEF,
   parameter int unsigned D_W      = D_W_DEF,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned TURN_CYC = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_en,
   input  logic [1:0]       req_we,
   input  logic [2*A_W-1:0] req_addr,
   input  logic [2*D_W-1:0] req_din,
   output logic [1:0]       gnt,
   output logic             mem_en,
   output logic             mem_we,
   output logic [A_W-1:0]   mem_addr,
   output logic [D_W-1:0]   mem_din,
   input  logic [D_W-1:0]   mem_dout,
`ifdef RAM_ARB_ECC_EN
   input  logic             mem_error,
   output logic             rsp_error,
   output logic [15:0]      err_cnt,
`endif
   output logic [1:0]       rsp_valid,
   output logic [D_W-1:0]   rsp_data,
   output logic             busy
);

   localparam int unsigned TC_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

   arb_state_e      state;
   req_id_t         rr_ptr;
   req_id_t         issue_id;
   logic            last_rd;
   logic [TC_W-1:0] turn_cnt;

   logic            win_valid;
   req_id_t         win_id;
   logic            win_we;
   logic [A_W-1:0]  win_addr;
   logic [D_W-1:0]  win_din;
   logic            bubble;
   logic            grant;

   rd_tag_t         tag_in;
   rd_tag_t         tag_tail;
   logic            tag_any;

   // Pick the winner; a write right after a read is held back for the turnaround.
   always_comb begin
      win_valid = 1'b0;
      win_id    = 1'b0;
      if (state != TURN) begin
         win_valid = |req_en;
         win_id    = (req_en == 2'b11) ? rr_ptr : req_en[1];
      end
      win_we   = req_we[win_id];
      win_addr = win_id ? req_addr[2*A_W-1:A_W] : req_addr[A_W-1:0];
      win_din  = win_id ? req_din[2*D_W-1:D_W] : req_din[D_W-1:0];
      bubble   = win_valid & win_we & last_rd & (TURN_CYC != 0);
      grant    = win_valid & ~bubble;
      gnt      = {grant & win_id, grant & ~win_id};
   end

   // FSM, round-robin pointer and registered command issue.
   // The cycle that detects a read->write conflict is itself the first bubble
   // cycle; TURN only covers any further bubble cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= 1'b0;
         last_rd  <= 1'b0;
         turn_cnt <= '0;
         issue_id <= 1'b0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else begin
         mem_en <= grant;
         mem_we <= grant & win_we;
         if (grant) begin
            mem_addr <= win_addr;
            mem_din  <= win_din;
            issue_id <= win_id;
            rr_ptr   <= ~win_id;
            last_rd  <= ~win_we;
         end
         if (bubble) last_rd <= 1'b0;
         case (state)
            TURN: begin
               if (turn_cnt == '0) state <= ISSUE;
               else turn_cnt <= turn_cnt - TC_W'(1);
            end
            default: begin
               if (bubble && (TURN_CYC > 1)) begin
                  state    <= TURN;
                  turn_cnt <= TC_W'((TURN_CYC > 1) ? TURN_CYC - 2 : 0);
               end else if (|req_en) begin
                  state <= ISSUE;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   // Tag the command currently on mem_* so its data returns RD_LAT cycles later.
   always_comb begin
      tag_in.valid = mem_en & ~mem_we;
      tag_in.id    = issue_id;
   end

   rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .tag_in    (tag_in),
      .tag_out   (tag_tail),
      .any_valid (tag_any)
   );

   // Route returning read data to the requester recorded in the tail tag.
   always_comb begin
      rsp_valid = {tag_tail.valid & tag_tail.id, tag_tail.valid & ~tag_tail.id};
      rsp_data  = tag_tail.valid ? mem_dout : '0;
      busy      = (state != IDLE) | tag_any | (mem_en & ~mem_we);
   end

`ifdef RAM_ARB_ECC_EN
   assign rsp_error = tag_tail.valid & mem_error;

   // Saturating count of reads that returned with an error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt <= '0;
      else if (rsp_error && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed stimulus, a cycle-level reference model
// plus literal expectations, and a simple latency-RD_LAT memory device.
// Honours RAM_ARB_ECC_EN when defined.
module tb_ram_port_arbiter;

   localparam int A_W      = 8;
   localparam int D_W      = 32;
   localparam int RD_LAT   = 2;
   localparam int TURN_CYC = 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_en;
   logic [1:0]       req_we;
   logic [2*A_W-1:0] req_addr;
   logic [2*D_W-1:0] req_din;
   logic [1:0]       gnt;
   logic             mem_en;
   logic             mem_we;
   logic [A_W-1:0]   mem_addr;
   logic [D_W-1:0]   mem_din;
   logic [D_W-1:0]   mem_dout;
   logic [1:0]       rsp_valid;
   logic [D_W-1:0]   rsp_data;
   logic             busy;
   logic             err_inj;
`ifdef RAM_ARB_ECC_EN
   logic             mem_error;
   logic             rsp_error;
   logic [15:0]      err_cnt;
   assign mem_error = err_inj;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .A_W(A_W), .D_W(D_W), .RD_LAT(RD_LAT), .TURN_CYC(TURN_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_en    (req_en),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_din   (req_din),
      .gnt       (gnt),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
`ifdef RAM_ARB_ECC_EN
      .mem_error (mem_error),
      .rsp_error (rsp_error),
      .err_cnt   (err_cnt),
`endif
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   // Power-on contents of the memory.
   function automatic logic [31:0] init_val(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(a));
   endfunction

   // Memory device: writes land at the end of the command cycle, reads return RD_LAT cycles later.
   bit   [31:0] dev_mem [256];
   bit          dev_wv  [256];
   logic [31:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         dev_mem[mem_addr] <= mem_din;
         dev_wv[mem_addr]  <= 1'b1;
      end
      rd_pipe[0] <= dev_wv[mem_addr] ? dev_mem[mem_addr] : init_val(mem_addr);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_dout = rd_pipe[RD_LAT-1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // Reference model state.
   int          m_rr, m_turn;
   bit          m_last_rd, m_prev;
   bit          e_en, e_we;
   logic [7:0]  e_addr;
   logic [31:0] e_din;
   bit   [31:0] mdl_mem [256];
   bit          mdl_wv  [256];
   bit   [1:0]  exp_rv  [64];
   bit   [31:0] exp_rd  [64];
   int          m_ecnt;

   // Model + per-cycle compare, mid-cycle.
   always @(negedge clk) begin
      int         slot, w, rs;
      logic [1:0] eg, ev;
      bit         outst;
      cyc++;
      slot = cyc % 64;
      if (!rst_n) begin
         chk("rst_gnt",   32'(gnt), 32'd0);
         chk("rst_en",    32'(mem_en), 32'd0);
         chk("rst_we",    32'(mem_we), 32'd0);
         chk("rst_addr",  32'(mem_addr), 32'd0);
         chk("rst_din",   mem_din, 32'd0);
         chk("rst_rsp",   32'(rsp_valid), 32'd0);
         chk("rst_busy",  32'(busy), 32'd0);
`ifdef RAM_ARB_ECC_EN
         chk("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
         m_rr = 0; m_turn = 0; m_last_rd = 0; m_prev = 0; m_ecnt = 0;
         e_en = 0; e_we = 0; e_addr = '0; e_din = '0;
         for (int i = 0; i < 64; i++) exp_rv[i] = 2'b00;
      end else begin
         eg = 2'b00;
         w  = 0;
         if (m_turn > 0) begin
            m_turn--;
         end else if (req_en != 2'b00) begin
            w = (req_en == 2'b11) ? m_rr : (req_en[1] ? 1 : 0);
            if (req_we[w] && m_last_rd && TURN_CYC > 0) begin
               m_last_rd = 0;
               m_turn    = TURN_CYC - 1;
            end else begin
               eg = 2'(1 << w);
            end
         end
         outst = 0;
         for (int k = 0; k <= RD_LAT; k++) if (exp_rv[(cyc + k) % 64] != 2'b00) outst = 1;
         ev = exp_rv[slot];

         chk("gnt",    32'(gnt), 32'(eg));
         chk("mem_en", 32'(mem_en), 32'(e_en));
         chk("mem_we", 32'(mem_we), 32'(e_we));
         chk("mem_addr", 32'(mem_addr), 32'(e_addr));
         chk("mem_din", mem_din, e_din);
         chk("rsp_valid", 32'(rsp_valid), 32'(ev));
         if (ev != 2'b00) chk("rsp_data", rsp_data, exp_rd[slot]);
         chk("busy", 32'(busy), 32'(m_prev || outst || m_turn > 0));
`ifdef RAM_ARB_ECC_EN
         chk("rsp_error", 32'(rsp_error), 32'((ev != 2'b00) && err_inj));
         chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
         if ((ev != 2'b00) && err_inj && m_ecnt < 16'hFFFF) m_ecnt++;
`endif
         exp_rv[slot] = 2'b00;

         if (eg != 2'b00) begin
            e_en   = 1;
            e_we   = req_we[w];
            e_addr = req_addr[w*A_W +: A_W];
            e_din  = req_din[w*D_W +: D_W];
            m_rr   = 1 - w;
            if (req_we[w]) begin
               mdl_mem[e_addr] = e_din;
               mdl_wv[e_addr]  = 1;
               m_last_rd       = 0;
            end else begin
               rs         = (cyc + 1 + RD_LAT) % 64;
               exp_rv[rs] = eg;
               exp_rd[rs] = mdl_wv[e_addr] ? mdl_mem[e_addr] : init_val(e_addr);
               m_last_rd  = 1;
            end
         end else begin
            e_en = 0;
            e_we = 0;
         end
         m_prev = (req_en != 2'b00);
      end
   end

   task automatic drive(input logic [1:0] en, input logic [1:0] we, input logic [7:0] a0,
                        input logic [7:0] a1, input logic [31:0] d0, input logic [31:0] d1);
      @(posedge clk);
      #1;
      req_en   = en;
      req_we   = we;
      req_addr = {a1, a0};
      req_din  = {d1, d0};
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; req_en = '0; req_we = '0; req_addr = '0; req_din = '0; err_inj = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mid();
      chk("L_reset_gnt", 32'(gnt), 32'd0);
      chk("L_reset_busy", 32'(busy), 32'd0);
      chk("L_reset_en", 32'(mem_en), 32'd0);

      // Both read continuously: alternating grants, responses three cycles later.
      for (int i = 0; i < 7; i++) begin
         drive((i < 4) ? 2'b11 : 2'b00, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
         mid();
         if (i < 4) chk("L_rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i >= 1 && i <= 4) chk("L_rr_en", 32'(mem_en), 32'd1);
         if (i >= 3) begin
            chk("L_rr_rsp", 32'(rsp_valid), ((i - 3) % 2 == 0) ? 32'd1 : 32'd2);
            chk("L_rr_data", rsp_data, ((i - 3) % 2 == 0) ? 32'h1000_0001 : 32'h1000_0002);
         end
      end
      idle(2);

      // Single read by requester 0.
      drive(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
      mid(); chk("L_rd_gnt", 32'(gnt), 32'd1);
      idle(1);
      mid();
      chk("L_rd_en", 32'(mem_en), 32'd1);
      chk("L_rd_we", 32'(mem_we), 32'd0);
      chk("L_rd_addr", 32'(mem_addr), 32'h10);
      idle(2);
      mid();
      chk("L_rd_rsp", 32'(rsp_valid), 32'd1);
      chk("L_rd_data", rsp_data, 32'hDEADBEEF);
      idle(2);

      // Read then write by requester 1: one bubble cycle.
      drive(2'b10, 2'b00, 8'h00, 8'h20, 32'h0, 32'h0);
      mid(); chk("L_rw_gnt0", 32'(gnt), 32'd2);
      drive(2'b10, 2'b10, 8'h00, 8'h20, 32'h0, 32'h55);
      mid(); chk("L_rw_bubble", 32'(gnt), 32'd0); chk("L_rw_en_rd", 32'(mem_en), 32'd1);
      drive(2'b10, 2'b10, 8'h00, 8'h20, 32'h0, 32'h55);
      mid(); chk("L_rw_gnt2", 32'(gnt), 32'd2); chk("L_rw_en_gap", 32'(mem_en), 32'd0);
      idle(1);
      mid();
      chk("L_rw_we", 32'(mem_we), 32'd1);
      chk("L_rw_din", mem_din, 32'h55);
      chk("L_rw_rsp", 32'(rsp_valid), 32'd2);
      chk("L_rw_data", rsp_data, 32'h1000_0020);
      idle(3);

      // Write then read back-to-back: no bubble.
      drive(2'b01, 2'b01, 8'h30, 8'h00, 32'hA5A5, 32'h0);
      mid(); chk("L_wr_gnt", 32'(gnt), 32'd1);
      drive(2'b01, 2'b00, 8'h30, 8'h00, 32'h0, 32'h0);
      mid(); chk("L_wr_gnt_rd", 32'(gnt), 32'd1);
      idle(1);
      mid(); chk("L_wr_rd_en", 32'(mem_en), 32'd1); chk("L_wr_rd_we", 32'(mem_we), 32'd0);
      idle(2);
      mid(); chk("L_wr_rsp", 32'(rsp_valid), 32'd1); chk("L_wr_data", rsp_data, 32'h0000A5A5);
      idle(3);

      // Contention mixing a writer and a reader.
      for (int i = 0; i < 6; i++) drive(2'b11, 2'b01, 8'h40, 8'h41, 32'h0000_0040, 32'h0);
      idle(5);

      // Reset with reads in flight.
      drive(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
      drive(2'b10, 2'b00, 8'h00, 8'h20, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      req_en = 2'b00;
      rst_n  = 1'b0;
      mid();
      chk("L_mr_en", 32'(mem_en), 32'd0);
      chk("L_mr_rsp", 32'(rsp_valid), 32'd0);
      chk("L_mr_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mid();
         chk("L_mr_no_rsp", 32'(rsp_valid), 32'd0);
         chk("L_mr_idle", 32'(busy), 32'd0);
         idle(1);
      end

`ifdef RAM_ARB_ECC_EN
      // Three reads returning with the error flag raised.
      err_inj = 1'b1;
      drive(2'b01, 2'b00, 8'h50, 8'h00, 32'h0, 32'h0);
      drive(2'b01, 2'b00, 8'h51, 8'h00, 32'h0, 32'h0);
      drive(2'b01, 2'b00, 8'h52, 8'h00, 32'h0, 32'h0);
      idle(4);
      mid();
      chk("L_ecc_cnt", 32'(err_cnt), 32'd3);
      err_inj = 1'b0;
      idle(2);
`endif

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
